// File: rtl/veda_req_sequencer.sv
// Command sequencer in front of the 32x32 Veda scratch memory: queues host requests and
// replays them onto the memory pins. Define VEDA_SEQ_STATS_EN to add wr/rd/stall counters.
module veda_req_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              busy,
  output logic              mem_write_enable,
  output logic              mem_mode,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
`ifdef VEDA_SEQ_STATS_EN
  ,
  output logic [15:0]       wr_count,
  output logic [15:0]       rd_count,
  output logic [15:0]       stall_count
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR       = 3'd1,
    RD_ISSUE = 3'd2,
    RD_WAIT  = 3'd3,
    RD_CAP   = 3'd4,
    RSP_HOLD = 3'd5
  } state_t;

  state_t            state_r;
  logic              fifo_write_r [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr_r  [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_r  [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W:0]    count_r;
  logic              empty_s;
  logic              push_s;
  logic              pop_s;

  // req_ready is a pure function of the stored count, so no input reaches it combinationally
  assign req_ready = (count_r != FULL_COUNT);
  assign empty_s   = (count_r == '0);
  assign push_s    = req_valid && req_ready;
  assign pop_s     = (state_r == IDLE) && !empty_s;
  assign busy      = !empty_s || (state_r != IDLE);

  // Command storage; contents need no reset because the count gates every read of it
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_write_r[wr_ptr_r] <= req_write;
      fifo_addr_r[wr_ptr_r]  <= req_addr;
      fifo_data_r[wr_ptr_r]  <= req_wdata;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (PTR_W+1)'(1);
        2'b01:   count_r <= count_r - (PTR_W+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sequencer FSM with registered memory pins and response channel
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r          <= IDLE;
      rsp_valid        <= 1'b0;
      rsp_data         <= '0;
      rsp_addr         <= '0;
      mem_write_enable <= 1'b0;
      mem_mode         <= 1'b1;
      mem_address      <= '0;
      mem_data_in      <= '0;
    end else begin
      mem_mode <= 1'b1;
      case (state_r)
        IDLE: begin
          mem_write_enable <= 1'b0;
          if (pop_s) begin
            mem_address <= fifo_addr_r[rd_ptr_r];
            if (fifo_write_r[rd_ptr_r]) begin
              mem_data_in      <= fifo_data_r[rd_ptr_r];
              mem_write_enable <= 1'b1;
              state_r          <= WR;
            end else begin
              state_r <= RD_ISSUE;
            end
          end
        end
        WR: begin
          mem_write_enable <= 1'b0;
          state_r          <= IDLE;
        end
        RD_ISSUE: state_r <= RD_WAIT;
        RD_WAIT:  state_r <= RD_CAP;
        RD_CAP: begin
          rsp_data  <= mem_data_out;
          rsp_addr  <= mem_address;
          rsp_valid <= 1'b1;
          state_r   <= RSP_HOLD;
        end
        RSP_HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          mem_write_enable <= 1'b0;
          rsp_valid        <= 1'b0;
          state_r          <= IDLE;
        end
      endcase
    end
  end

`ifdef VEDA_SEQ_STATS_EN
  // Free-running activity counters that wrap naturally at 16 bits
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_count    <= 16'd0;
      rd_count    <= 16'd0;
      stall_count <= 16'd0;
    end else begin
      if (state_r == WR)            wr_count    <= wr_count + 16'd1;
      if (state_r == RD_CAP)        rd_count    <= rd_count + 16'd1;
      if (req_valid && !req_ready)  stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_veda_req_sequencer.sv
// Directed self-checking bench for veda_req_sequencer with a behavioural model of the
// 2-edge registered Veda scratch memory driven from the DUT pins.
module tb_veda_req_sequencer;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_addr;
  logic        busy;
  logic        mem_write_enable;
  logic        mem_mode;
  logic [4:0]  mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
`ifdef VEDA_SEQ_STATS_EN
  logic [15:0] wr_count;
  logic [15:0] rd_count;
  logic [15:0] stall_count;
`endif

  int checks;
  int failures;

  logic [31:0] mem_model [32];
  logic [31:0] mem_stage;

  veda_req_sequencer #(.FIFO_DEPTH(4), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_addr(rsp_addr),
    .busy(busy),
    .mem_write_enable(mem_write_enable), .mem_mode(mem_mode),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
`ifdef VEDA_SEQ_STATS_EN
    , .wr_count(wr_count), .rd_count(rd_count), .stall_count(stall_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: write at the edge ending a write cycle, read through two registers
  always @(posedge clk) begin
    if (mem_write_enable) mem_model[mem_address] <= mem_data_in;
    mem_stage    <= mem_model[mem_address];
    mem_data_out <= mem_stage;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic w, input logic [4:0] a, input logic [31:0] d);
    logic acc;
    acc       = 1'b0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    for (int n = 0; n < 200 && !acc; n++) begin
      acc = req_ready;
      tick();
    end
    req_valid = 1'b0;
    check("push_accept", 32'(acc), 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    for (int n = 0; n < 100 && rsp_valid !== 1'b1; n++) tick();
    check(tag, 32'(rsp_valid), 32'd1);
  endtask

  task automatic expect_rsp(input string tag, input logic [4:0] a, input logic [31:0] d,
                            input int hold);
    wait_valid({tag, "_valid"});
    check({tag, "_data"}, rsp_data, d);
    check({tag, "_addr"}, 32'(rsp_addr), 32'(a));
    for (int h = 0; h < hold; h++) begin
      tick();
      check({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "_hold_data"}, rsp_data, d);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, "_drop"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic seen;
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 5'd0;
    req_wdata = 32'd0;
    rsp_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset / idle state
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_mem_we", 32'(mem_write_enable), 32'd0);
    check("rst_mem_mode", 32'(mem_mode), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_addr", 32'(mem_address), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);

    // Single write: one-cycle enable pulse, memory updated at E2
    push(1'b1, 5'd5, 32'hDEADBEEF);
    check("wr_e0_we", 32'(mem_write_enable), 32'd0);
    check("wr_e0_busy", 32'(busy), 32'd1);
    tick();
    check("wr_e1_we", 32'(mem_write_enable), 32'd1);
    check("wr_e1_addr", 32'(mem_address), 32'd5);
    check("wr_e1_din", mem_data_in, 32'hDEADBEEF);
    check("wr_e1_mode", 32'(mem_mode), 32'd1);
    tick();
    check("wr_e2_we", 32'(mem_write_enable), 32'd0);
    check("wr_e2_mem", mem_model[5], 32'hDEADBEEF);
    check("wr_e2_busy", 32'(busy), 32'd0);

    // Standalone read: rsp_valid rises exactly at E4
    push(1'b0, 5'd5, 32'd0);
    for (int k = 1; k < 4; k++) begin
      tick();
      check("rd_lat_early", 32'(rsp_valid), 32'd0);
    end
    tick();
    check("rd_lat_e4", 32'(rsp_valid), 32'd1);
    check("rd_data", rsp_data, 32'hDEADBEEF);
    check("rd_addr", 32'(rsp_addr), 32'd5);
    check("rd_mode", 32'(mem_mode), 32'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rd_accept", 32'(rsp_valid), 32'd0);

    // Full sweep: write addr*3 everywhere, then read every word back in order
    for (int a = 0; a < 32; a++) push(1'b1, 5'(a), 32'(a * 3));
    for (int a = 0; a < 32; a++) begin
      push(1'b0, 5'(a), 32'd0);
      expect_rsp("sweep", 5'(a), 32'(a * 3), 0);
    end

    // Backpressure: first response held, four more reads fill the FIFO, fifth must wait
    push(1'b0, 5'd1, 32'd0);
    wait_valid("bp_first_valid");
    for (int a = 2; a < 6; a++) push(1'b0, 5'(a), 32'd0);
    check("bp_full_ready", 32'(req_ready), 32'd0);
    check("bp_full_busy", 32'(busy), 32'd1);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 5'd6;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_stall_ready", 32'(req_ready), 32'd0);
      check("bp_stall_valid", 32'(rsp_valid), 32'd1);
      check("bp_stall_data", rsp_data, 32'd3);
      check("bp_stall_addr", 32'(rsp_addr), 32'd1);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_first_drop", 32'(rsp_valid), 32'd0);
    check("bp_still_full", 32'(req_ready), 32'd0);
    tick();
    check("bp_pop_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    check("bp_fifth_taken", 32'(req_ready), 32'd0);
    for (int a = 2; a < 7; a++) expect_rsp("bp_order", 5'(a), 32'(a * 3), 2);
    check("bp_drained", 32'(busy), 32'd0);

    // Reset while in RD_WAIT with two commands queued
    push(1'b0, 5'd7, 32'd0);
    push(1'b1, 5'd8, 32'h00000BAD);
    push(1'b0, 5'd9, 32'd0);
    check("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_busy_clr", 32'(busy), 32'd0);
    check("mid_req_ready", 32'(req_ready), 32'd1);
    check("mid_mem_we", 32'(mem_write_enable), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (rsp_valid || mem_write_enable) seen = 1'b1;
    end
    check("mid_no_stale", 32'(seen), 32'd0);
    push(1'b0, 5'd8, 32'd0);
    expect_rsp("mid_discarded_wr", 5'd8, 32'd24, 0);

`ifdef VEDA_SEQ_STATS_EN
    // Counters: 3 writes, 2 reads, 4 full-FIFO stall cycles
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("st_clear_wr", 32'(wr_count), 32'd0);
    push(1'b0, 5'd10, 32'd0);
    wait_valid("st_first_valid");
    push(1'b1, 5'd20, 32'd111);
    push(1'b1, 5'd21, 32'd222);
    push(1'b1, 5'd22, 32'd333);
    push(1'b0, 5'd20, 32'd0);
    check("st_full", 32'(req_ready), 32'd0);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 5'd23;
    for (int k = 0; k < 4; k++) tick();
    req_valid = 1'b0;
    expect_rsp("st_rd1", 5'd10, 32'd30, 0);
    expect_rsp("st_rd2", 5'd20, 32'd111, 0);
    check("st_idle", 32'(busy), 32'd0);
    check("st_wr_count", 32'(wr_count), 32'd3);
    check("st_rd_count", 32'(rd_count), 32'd2);
    check("st_stall_count", 32'(stall_count), 32'd4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/veda_req_sequencer.md
Name: veda_req_sequencer

Overview:
- Front-end command sequencer that sits directly upstream of the 32x32 Veda scratch memory.
- Accepts host read/write requests over a valid/ready interface and buffers them in a small command FIFO.
- Drives the memory's write_enable/mode/address/data_in pins and captures the memory's 2-edge registered read data.
- Returns each read result to the host over a valid/ready response channel.

Parameters:
FIFO_DEPTH, 4, command FIFO entries; power of two, >= 2
ADDR_W, 5, memory address width (32 words)
DATA_W, 32, memory data width

Ports:
clk  in  1  single clock; all logic on posedge
reset  in  1  synchronous, active-high
req_valid  in  1  host request valid
req_ready  out  1  FIFO can accept; equals !fifo_full
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  write data (ignored for reads)
rsp_valid  out  1  read response valid
rsp_ready  in  1  host accepts response
rsp_data  out  DATA_W  read data
rsp_addr  out  ADDR_W  address of the returned read
busy  out  1  FIFO non-empty or FSM not in IDLE
mem_write_enable  out  1  to memory write_enable
mem_mode  out  1  to memory mode (0 = scribble, 1 = interpret)
mem_address  out  ADDR_W  to memory address
mem_data_in  out  DATA_W  to memory data_in
mem_data_out  in  DATA_W  from memory data_out

Behaviour:
- Reset is synchronous, active-high, and wins over all other activity. On reset:
  - FIFO pointers and count = 0
  - FSM = IDLE
  - rsp_valid = 0, rsp_data = 0, rsp_addr = 0
  - mem_write_enable = 0, mem_mode = 1, mem_address = 0, mem_data_in = 0
- Reset mid-operation discards any in-flight read and all queued commands; no response is produced for them.
- Push: on an edge with req_valid && req_ready. Push and pop may occur on the same edge; count is unchanged.
- A request offered while the FIFO is full is not accepted. The host must hold it; the block does not drop it.
- All mem_* outputs are registered and follow the FSM state. mem_mode is never 0: the sequencer never uses scribble mode.
- FSM states:
  - IDLE: mem_write_enable = 0, mem_mode = 1, address held.
    - If FIFO non-empty: pop head; go to WR (write) or RD_ISSUE (read), loading mem_address/mem_data_in.
  - WR: mem_write_enable = 1 for exactly one cycle; memory is written at the end of this cycle. Next state IDLE.
  - RD_ISSUE: mem_write_enable = 0, mem_mode = 1, address driven. The memory's intermediate register loads at the end of this cycle. Next state RD_WAIT.
  - RD_WAIT: address and mode held; memory data_out updates at the end of this cycle. Next state RD_CAP.
  - RD_CAP: on the edge, rsp_data <= mem_data_out, rsp_addr <= address, rsp_valid <= 1. Next state RSP_HOLD.
  - RSP_HOLD: rsp_valid, rsp_data and rsp_addr stay stable until rsp_ready. On the accepting edge rsp_valid <= 0 and FSM goes to IDLE.
- Latency with an empty FIFO and the FSM in IDLE (accept edge E0):
  - Write: memory is updated at edge E2.
  - Read: rsp_valid rises at edge E4.
- Throughput: one write per 2 cycles; one read per 5 cycles with rsp_ready held high.
- Ordering: strict FIFO order, so read-after-write to the same address returns the new data.
- Backpressure: while in RSP_HOLD no further commands are popped.
- req_ready depends only on the FIFO count. It has no combinational path from req_valid or rsp_ready.

Optional Feature:
- Macro: VEDA_SEQ_STATS_EN.
- When defined, adds three outputs:
  - wr_count[15:0]: +1 on each WR cycle.
  - rd_count[15:0]: +1 on each RD_CAP.
  - stall_count[15:0]: +1 each cycle req_valid && !req_ready.
- All three counters wrap at 16'hFFFF -> 0 and clear on reset.
- When not defined, these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Reset then idle -> req_ready = 1, rsp_valid = 0, mem_write_enable = 0, mem_mode = 1, busy = 0.
- Write addr 5 = 32'hDEADBEEF, then read addr 5, rsp_ready = 1 -> one-cycle mem_write_enable pulse with address 5; rsp_data = 32'hDEADBEEF, rsp_addr = 5. With an empty FIFO, a standalone read's rsp_valid rises exactly 4 edges after its accept.
- Push 5 back-to-back reads (FIFO_DEPTH = 4) with rsp_ready = 0 -> req_ready falls after 4 accepts, then re-asserts only as entries pop. No request is lost; responses arrive in order, each held until rsp_ready.
- Writes to addresses 0..31 with data = addr*3, then reads of all 32 -> every rsp_data = addr*3. Address 31 wraps correctly.
- Assert reset during RD_WAIT with 2 queued commands -> next cycle rsp_valid = 0, busy = 0, FIFO empty; no stale response appears afterwards.
- With VEDA_SEQ_STATS_EN: 3 writes, 2 reads, and 4 full-FIFO stall cycles -> wr_count = 3, rd_count = 2, stall_count = 4.
